// File: rtl/bw_div_pkg.sv
// Shared types and sizing helpers for the signed divider.
package bw_div_pkg;

  localparam int unsigned DefaultN = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Bits needed to count the 2N restoring steps.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/bw_twos_negate.sv
// Conditional two's-complement negate; passes the input through when neg is low.
module bw_twos_negate #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic             neg,
  output logic [Width-1:0] y
);

  // Negate by invert-and-increment only when requested.
  always_comb begin
    y = neg ? (~a + Width'(1)) : a;
  end

endmodule

// File: rtl/bw_signed_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring, MSB first.
module bw_signed_divider
  import bw_div_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LastCnt = CW'(2 * N - 1);
  localparam logic [W2-1:0] MinDd = {1'b1, {(W2 - 1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   dd_q, dd_d;          // |dividend|, shifted out MSB first
  logic [W2-1:0]   qacc_q, qacc_d;      // unsigned quotient being built
  logic [N:0]      rem_q, rem_d;        // partial remainder
  logic [N-1:0]    dv_q, dv_d;          // |divisor|
  logic            sdd_q, sdd_d;
  logic            sdv_q, sdv_d;
  logic [W2-1:0]   dvd_raw_q, dvd_raw_d;
  logic [W2-1:0]   quot_q, quot_d;
  logic [N-1:0]    remo_q, remo_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;

  logic [W2-1:0]   abs_dd;
  logic [N-1:0]    abs_dv;
  logic [W2-1:0]   q_signed;
  logic [N-1:0]    r_signed;
  logic [N+1:0]    shifted;
  logic [N+1:0]    trial;

  // |dividend| of the most negative value is still correct read as unsigned.
  bw_twos_negate #(.Width(W2)) u_abs_dd (
    .a   (dividend),
    .neg (dividend[W2-1]),
    .y   (abs_dd)
  );

  bw_twos_negate #(.Width(N)) u_abs_dv (
    .a   (divisor),
    .neg (divisor[N-1]),
    .y   (abs_dv)
  );

  bw_twos_negate #(.Width(W2)) u_fix_q (
    .a   (qacc_q),
    .neg (sdd_q ^ sdv_q),
    .y   (q_signed)
  );

  bw_twos_negate #(.Width(N)) u_fix_r (
    .a   (rem_q[N-1:0]),
    .neg (sdd_q),
    .y   (r_signed)
  );

  // One restoring step; the extra top bit of trial carries the borrow.
  assign shifted = {rem_q, dd_q[W2-1]};
  assign trial   = shifted - {2'b00, dv_q};

  // Next-state, datapath and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dd_d      = dd_q;
    qacc_d    = qacc_q;
    rem_d     = rem_q;
    dv_d      = dv_q;
    sdd_d     = sdd_q;
    sdv_d     = sdv_q;
    dvd_raw_d = dvd_raw_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          dd_d      = abs_dd;
          dv_d      = abs_dv;
          sdd_d     = dividend[W2-1];
          sdv_d     = divisor[N-1];
          dvd_raw_d = dividend;
          rem_d     = '0;
          qacc_d    = '0;
        end
      end
      StCalc: begin
        dd_d = {dd_q[W2-2:0], 1'b0};
        if (!trial[N+1]) begin
          rem_d  = trial[N:0];
          qacc_d = {qacc_q[W2-2:0], 1'b1};
        end else begin
          rem_d  = shifted[N:0];
          qacc_d = {qacc_q[W2-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dv_q == '0) begin
          quot_d = '1;
          remo_d = dvd_raw_q[N-1:0];
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
        end else if (sdv_q && (dv_q == N'(1)) && (dvd_raw_q == MinDd)) begin
          quot_d = dvd_raw_q;
          remo_d = '0;
          dz_d   = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          quot_d = q_signed;
          remo_d = r_signed;
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dd_q      <= '0;
      qacc_q    <= '0;
      rem_q     <= '0;
      dv_q      <= '0;
      sdd_q     <= 1'b0;
      sdv_q     <= 1'b0;
      dvd_raw_q <= '0;
      quot_q    <= '0;
      remo_q    <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dd_q      <= dd_d;
      qacc_q    <= qacc_d;
      rem_q     <= rem_d;
      dv_q      <= dv_d;
      sdd_q     <= sdd_d;
      sdv_q     <= sdv_d;
      dvd_raw_q <= dvd_raw_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule
